// File: rtl/ov7670_sccb_config.sv
// OV7670 power-up sequencer: walks a fixed register table and writes each entry over SCCB.
// Optional macro SCCB_ACK_CHECK_EN enables NACK detection, per-entry retry and ERR.
module ov7670_sccb_config #(
    parameter int          CLK_DIV    = 250,
    parameter logic [7:0]  DEV_ID     = 8'h42,
    parameter int          NUM_REGS   = 16,
    parameter int          RESET_WAIT = 1000000,
    parameter int          GAP_CYCLES = 4 * CLK_DIV,
    parameter int          MAX_RETRY  = 3
) (
    input  logic       FSM_CLK,
    input  logic       RST,
    input  logic       START,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic [5:0] CFG_IDX,
    output logic       CAPTURE_READY,
    output logic       SIOC,
    output logic       SIOD_O,
    output logic       SIOD_OE,
    input  logic       SIOD_I
);

`ifdef SCCB_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif

    localparam int QW   = $clog2(CLK_DIV + 1);
    localparam int WMAX = (RESET_WAIT > GAP_CYCLES) ? RESET_WAIT : GAP_CYCLES;
    localparam int WW   = $clog2(WMAX + 1);
    localparam int RW   = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BIT, S_STOP, S_GAP, S_RWAIT, S_DONE, S_ERROR
    } state_t;

    state_t         state_q;
    logic [QW-1:0]  qcnt_q;
    logic [1:0]     qtr_q;
    logic [3:0]     bitn_q;
    logic [1:0]     byte_q;
    logic [23:0]    sh_q;
    logic [WW-1:0]  wait_q;
    logic [RW-1:0]  retry_q;
    logic           nack_q;
    logic           busy_q, done_q, err_q;
    logic [5:0]     idx_q;
    logic           sioc_q, siod_q, oe_q;

    logic [15:0] entry_d;
    logic        qend, is_ack, last_slot, soft_rst, last_entry;

    always_comb begin
        entry_d = 16'hFFFF;
        case (idx_q)
            6'd0:    entry_d = 16'h1280;
            6'd1:    entry_d = 16'h1214;
            6'd2:    entry_d = 16'h40D0;
            6'd3:    entry_d = 16'h1101;
            6'd4:    entry_d = 16'h0C04;
            6'd5:    entry_d = 16'h3E19;
            6'd6:    entry_d = 16'h7211;
            6'd7:    entry_d = 16'h73F1;
            6'd8:    entry_d = 16'hA202;
            6'd9:    entry_d = 16'h1716;
            6'd10:   entry_d = 16'h1804;
            6'd11:   entry_d = 16'h3224;
            6'd12:   entry_d = 16'h1902;
            6'd13:   entry_d = 16'h1A7A;
            6'd14:   entry_d = 16'h030A;
            6'd15:   entry_d = 16'h3A04;
            default: entry_d = 16'hFFFF;
        endcase
    end

    assign qend       = (qcnt_q == QW'(CLK_DIV - 1));
    assign is_ack     = (bitn_q == 4'd8);
    assign last_slot  = is_ack && (byte_q == 2'd2);
    assign soft_rst   = (entry_d[15:8] == 8'h12) && entry_d[7];
    assign last_entry = (idx_q == 6'(NUM_REGS - 1));

    always_ff @(posedge FSM_CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
            qtr_q   <= 2'd0;
            bitn_q  <= 4'd0;
            byte_q  <= 2'd0;
            sh_q    <= '0;
            wait_q  <= '0;
            retry_q <= '0;
            nack_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= 6'd0;
            sioc_q  <= 1'b1;
            siod_q  <= 1'b1;
            oe_q    <= 1'b1;
        end else begin
            qcnt_q <= qend ? '0 : qcnt_q + QW'(1);
            if (qend) qtr_q <= qtr_q + 2'd1;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (START) begin
                        state_q <= S_START;
                        qcnt_q  <= '0;
                        qtr_q   <= 2'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        idx_q   <= 6'd0;
                        retry_q <= '0;
                        nack_q  <= 1'b0;
                        sioc_q  <= 1'b1;
                        siod_q  <= 1'b1;
                        oe_q    <= 1'b1;
                    end
                end
                S_START: begin
                    if (qend) begin
                        case (qtr_q)
                            2'd0: siod_q <= 1'b0;
                            2'd1: sioc_q <= 1'b0;
                            2'd3: begin
                                state_q <= S_BIT;
                                bitn_q  <= 4'd0;
                                byte_q  <= 2'd0;
                                siod_q  <= DEV_ID[7];
                                sh_q    <= {DEV_ID[6:0], entry_d, 1'b0};
                            end
                            default: ;
                        endcase
                    end
                end
                S_BIT: begin
                    if (qend) begin
                        case (qtr_q)
                            2'd1: sioc_q <= 1'b1;
                            2'd2: if (ACK_CHECK && is_ack && SIOD_I) nack_q <= 1'b1;
                            2'd3: begin
                                sioc_q <= 1'b0;
                                if (last_slot) begin
                                    state_q <= S_STOP;
                                    siod_q  <= 1'b0;
                                    oe_q    <= 1'b1;
                                end else if (is_ack) begin
                                    bitn_q <= 4'd0;
                                    byte_q <= byte_q + 2'd1;
                                    siod_q <= sh_q[23];
                                    sh_q   <= {sh_q[22:0], 1'b0};
                                    oe_q   <= 1'b1;
                                end else if (bitn_q == 4'd7) begin
                                    // Release the line so the sensor can drive ACK.
                                    bitn_q <= 4'd8;
                                    siod_q <= 1'b1;
                                    oe_q   <= 1'b0;
                                end else begin
                                    bitn_q <= bitn_q + 4'd1;
                                    siod_q <= sh_q[23];
                                    sh_q   <= {sh_q[22:0], 1'b0};
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_STOP: begin
                    if (qend) begin
                        case (qtr_q)
                            2'd0: sioc_q <= 1'b1;
                            2'd1: siod_q <= 1'b1;
                            2'd3: begin
                                state_q <= soft_rst ? S_RWAIT : S_GAP;
                                wait_q  <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RWAIT: begin
                    if (wait_q == WW'(RESET_WAIT - 1)) begin
                        state_q <= S_GAP;
                        wait_q  <= '0;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                S_GAP: begin
                    if (wait_q == WW'(GAP_CYCLES - 1)) begin
                        wait_q <= '0;
                        qcnt_q <= '0;
                        qtr_q  <= 2'd0;
                        nack_q <= 1'b0;
                        if (nack_q) begin
                            if (retry_q == RW'(MAX_RETRY)) begin
                                state_q <= S_ERROR;
                                busy_q  <= 1'b0;
                                err_q   <= 1'b1;
                            end else begin
                                state_q <= S_START;
                                retry_q <= retry_q + RW'(1);
                            end
                        end else if (last_entry) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_START;
                            idx_q   <= idx_q + 6'd1;
                            retry_q <= '0;
                        end
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign ERR           = err_q;
    assign CFG_IDX       = idx_q;
    assign CAPTURE_READY = done_q;
    assign SIOC          = sioc_q;
    assign SIOD_O        = siod_q;
    assign SIOD_OE       = oe_q;

endmodule
